noc_local_injector: RTL and testbench
=====================================

NOC_LOCAL_INJECTOR -- requirements
Module: noc_local_injector

Interface
REQ-001 SHALL have parameter LINK_WIDTH, default 8, meaning flit width in bits (minimum 8).
REQ-002 SHALL have parameter MESH_ROWS, default 4, meaning mesh row count.
REQ-003 SHALL have parameter MESH_COLUMNS, default 4, meaning mesh column count.
REQ-004 SHALL have parameter LEN_W, default 4, meaning width of the payload-length field.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port pkt_valid, input, 1 bit: packet request valid.
REQ-008 SHALL have port pkt_ready, output, 1 bit: packet request accepted.
REQ-009 SHALL have port pkt_dest, input, LINK_WIDTH-2 bits: destination router ID.
REQ-010 SHALL have port pkt_len, input, LEN_W bits: payload flit count.
REQ-011 SHALL have port pay_valid, input, 1 bit: payload word valid.
REQ-012 SHALL have port pay_ready, output, 1 bit: payload word consumed.
REQ-013 SHALL have port pay_data, input, LINK_WIDTH-2 bits: payload word.
REQ-014 SHALL have port local_in_flit, output, LINK_WIDTH bits: flit to the router local input port.
REQ-015 SHALL have port local_wr_en, output, 1 bit: flit write strobe.
REQ-016 SHALL have port router_out_full, input, 1 bit: router local input buffer full (OFF).
REQ-017 SHALL have port busy, output, 1 bit: packet in progress.
REQ-018 SHALL have port pkt_count, output, 16 bits: completed packets, wrapping.
REQ-019 SHALL have port err_zero_len, output, 1 bit: one-cycle pulse marking a dropped zero-length request.

Function
REQ-020 SHALL format flits as {type[1:0], field[LINK_WIDTH-3:0]}, with types HEAD=01, BODY=10 and TAIL=11; a HEAD flit's field carries pkt_dest, and a BODY or TAIL flit's field carries pay_data.
REQ-021 SHALL implement an FSM with states IDLE, HEAD and PAYLOAD.
REQ-022 SHALL drive pkt_ready=1 only in IDLE; a request is accepted when pkt_valid and pkt_ready are both 1 at a rising edge.
REQ-023 SHALL, on acceptance with pkt_len>0, capture dest and len and move to HEAD, presenting the head flit in the next cycle (1-cycle latency).
REQ-024 SHALL, on acceptance with pkt_len=0, stay in IDLE, emit no flits, and pulse err_zero_len for one cycle.
REQ-025 SHALL, in HEAD, drive local_wr_en = !router_out_full combinationally, hold the head flit stable, and move to PAYLOAD on the cycle where local_wr_en=1.
REQ-026 SHALL, in PAYLOAD, drive pay_ready = !router_out_full and local_wr_en = pay_valid && !router_out_full, using type TAIL when the remaining count is 1 and BODY otherwise.
REQ-027 SHALL decrement the remaining count by one on each PAYLOAD write; the TAIL write returns the FSM to IDLE and increments pkt_count.
REQ-028 SHALL never assert local_wr_en in a cycle where router_out_full=1, including when it asserts mid-packet; the current flit is held until router_out_full deasserts, with no loss or duplication.
REQ-029 SHALL drive local_in_flit=0 and local_wr_en=0 in IDLE.
REQ-030 SHALL insert exactly one IDLE cycle between the TAIL write and the next HEAD presentation.
REQ-031 SHALL set busy=1 in HEAD and PAYLOAD.
REQ-032 SHALL forward pkt_dest unchanged, including the injector's own ID and out-of-range IDs.
REQ-033 SHALL wrap pkt_count from 0xFFFF to 0.

Reset
REQ-034 SHALL, with rst=1 at a rising edge, set state=IDLE, remaining=0, pkt_count=0 and err_zero_len=0; outputs follow REQ-029 and pkt_ready=1 from the first cycle after reset.
REQ-035 SHALL, when rst is asserted mid-packet, abandon the packet immediately with no TAIL sent; recovery of the router wormhole is handled at system level by resetting the whole mesh together.

Structure
REQ-036 SHALL take the flit type constants (HEAD, BODY, TAIL) and the flit-field width function from shared package noc_pkg, which is also used by the router.
REQ-037 SHALL be a single module (FSM plus datapath) with no sub-module required.

Verification
REQ-038 SHALL verify: with LINK_WIDTH=8, dest=5, len=3, payloads 0x11/0x22/0x33, full=0 -> flits 0x45, 0x91, 0xA2, 0xF3 in 4 consecutive cycles, then pkt_count=1.
REQ-039 SHALL verify: router_out_full=1 for 3 cycles during the second BODY flit -> local_wr_en=0 and pay_ready=0 in those cycles, and the flit sequence is identical to the stall-free case.
REQ-040 SHALL verify: pay_valid low for 2 cycles mid-packet -> no writes in those cycles, and the packet completes correctly.
REQ-041 SHALL verify: pkt_len=0 -> no local_wr_en, err_zero_len high for 1 cycle, and pkt_ready high the next cycle.
REQ-042 SHALL verify: two back-to-back requests with len=1 each -> HEAD, TAIL, one idle cycle, HEAD, TAIL, with pkt_count=2.
REQ-043 SHALL verify: rst asserted after the head flit -> the next cycle has IDLE, local_wr_en=0 and pkt_count=0, and a new packet then sends correctly.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, field width helper and the
// injector FSM state encoding.
package noc_pkg;

  typedef enum logic [1:0] {
    FLIT_NONE = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_BODY = 2'b10,
    FLIT_TAIL = 2'b11
  } flit_type_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_HEAD    = 2'b01,
    ST_PAYLOAD = 2'b10
  } inj_state_t;

  // A flit is {type[1:0], field}; the field gets everything but the type bits.
  function automatic int field_width(input int link_width);
    return link_width - 2;
  endfunction

endpackage

// File: rtl/noc_local_injector_if.sv
// Request, payload and router-link signals of the local injector.
// master = traffic source + router side, slave = the injector.
interface noc_local_injector_if
  import noc_pkg::*;
#(
  parameter int LINK_WIDTH = 8,
  parameter int LEN_W      = 4
) ();

  localparam int FW = field_width(LINK_WIDTH);

  logic                  pkt_valid;
  logic                  pkt_ready;
  logic [FW-1:0]         pkt_dest;
  logic [LEN_W-1:0]      pkt_len;
  logic                  pay_valid;
  logic                  pay_ready;
  logic [FW-1:0]         pay_data;
  logic [LINK_WIDTH-1:0] local_in_flit;
  logic                  local_wr_en;
  logic                  router_out_full;
  logic                  busy;
  logic [15:0]           pkt_count;
  logic                  err_zero_len;

  modport master (
    output pkt_valid, pkt_dest, pkt_len, pay_valid, pay_data, router_out_full,
    input  pkt_ready, pay_ready, local_in_flit, local_wr_en, busy, pkt_count,
           err_zero_len
  );

  modport slave (
    input  pkt_valid, pkt_dest, pkt_len, pay_valid, pay_data, router_out_full,
    output pkt_ready, pay_ready, local_in_flit, local_wr_en, busy, pkt_count,
           err_zero_len
  );

endinterface

// File: rtl/noc_local_injector.sv
// Local injector: turns a {dest, len} request plus a payload stream into a
// HEAD/BODY.../TAIL flit sequence on the router's local input port.
module noc_local_injector
  import noc_pkg::*;
#(
  parameter int LINK_WIDTH   = 8,
  parameter int MESH_ROWS    = 4,
  parameter int MESH_COLUMNS = 4,
  parameter int LEN_W        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  noc_local_injector_if.slave  bus,
  output inj_state_t           dbg_state
);

  localparam int FW    = field_width(LINK_WIDTH);
  localparam int NODES = MESH_ROWS * MESH_COLUMNS;

  // Destinations are forwarded verbatim; IDs outside the mesh are the
  // router's concern, so the mesh size places no constraint here.
  if (NODES > (1 << FW)) begin : g_mesh_wider_than_id
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. local_wr_en is a plain strobe, only ever raised while the router
  // reports room (router_out_full == 0).

  inj_state_t        state_q, state_d;
  logic [FW-1:0]     dest_q;
  logic [LEN_W-1:0]  rem_q;
  logic [15:0]       pkt_count_q;
  logic              err_q;

  logic                  pkt_ready_c;
  logic                  pay_ready_c;
  logic                  wr_c;
  logic [LINK_WIDTH-1:0] flit_c;
  flit_type_t            pay_type_c;
  logic                  accept_c;
  logic                  tail_wr_c;

  assign accept_c = bus.pkt_valid && pkt_ready_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dest_q      <= '0;
      rem_q       <= '0;
      pkt_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept_c && (bus.pkt_len == '0);
      if (accept_c && (bus.pkt_len != '0)) begin
        dest_q <= bus.pkt_dest;
        rem_q  <= bus.pkt_len;
      end else if ((state_q == ST_PAYLOAD) && wr_c) begin
        rem_q <= rem_q - 1'b1;
      end
      if (tail_wr_c) begin
        pkt_count_q <= pkt_count_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pkt_ready_c = 1'b0;
    pay_ready_c = 1'b0;
    wr_c        = 1'b0;
    flit_c      = '0;
    tail_wr_c   = 1'b0;
    pay_type_c  = (rem_q == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY;
    case (state_q)
      ST_IDLE: begin
        pkt_ready_c = 1'b1;
        if (bus.pkt_valid && (bus.pkt_len != '0)) state_d = ST_HEAD;
      end
      ST_HEAD: begin
        flit_c = {FLIT_HEAD, dest_q};
        wr_c   = !bus.router_out_full;
        if (wr_c) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        pay_ready_c = !bus.router_out_full;
        wr_c        = bus.pay_valid && !bus.router_out_full;
        flit_c      = {pay_type_c, bus.pay_data};
        if (wr_c && (pay_type_c == FLIT_TAIL)) begin
          tail_wr_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.pkt_ready     = pkt_ready_c;
  assign bus.pay_ready     = pay_ready_c;
  assign bus.local_wr_en   = wr_c;
  assign bus.local_in_flit = flit_c;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.pkt_count     = pkt_count_q;
  assign bus.err_zero_len  = err_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_noc_local_injector.sv
// Bench for noc_local_injector: directed packet scenarios plus randomized
// traffic, with written flits checked against a packet-level model.
module tb_noc_local_injector;
  import noc_pkg::*;

  localparam int LW = 8;
  localparam int FW = LW - 2;
  localparam int LEN_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  inj_state_t dbg_state;

  noc_local_injector_if #(.LINK_WIDTH(LW), .LEN_W(LEN_W)) bus ();

  noc_local_injector #(
    .LINK_WIDTH(LW), .MESH_ROWS(4), .MESH_COLUMNS(4), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard ----------------
  logic [LW-1:0] exp_q[$];
  int            wr_cyc_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            exp_count = 0;
  bit            rnd_full = 1'b0;
  logic [FW-1:0] words[16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every written flit must be the next one the model predicts.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.router_out_full) check("wr_while_full", bus.local_wr_en, 0);
      if (bus.local_wr_en) begin
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_wr", bus.local_wr_en, 0);
        else check("flit", bus.local_in_flit, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_full) bus.router_out_full = ($urandom_range(0, 2) == 0);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept(input logic [FW-1:0] dest, input logic [LEN_W-1:0] len);
    bit got;
    got = 1'b0;
    bus.pkt_valid = 1'b1;
    bus.pkt_dest  = dest;
    bus.pkt_len   = len;
    for (int g = 0; g < 100 && !got; g++) begin
      @(negedge clk);
      got = bus.pkt_ready;
      @(posedge clk); #1;
    end
    if (!got) check("accept_timeout", bus.pkt_ready, 1);
    bus.pkt_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [FW-1:0] dest, input int len,
                          input int stall_at, input int gap_at, input bit rand_gaps);
    int  waited;
    int  pcyc;
    bit  hs;
    // Model: one head carrying dest, then len payload flits, the last a tail.
    exp_q.push_back({2'b01, dest});
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1) ? 2'b11 : 2'b10, words[i]});

    wait_accept(dest, LEN_W'(len));
    waited = 0;
    hs = 1'b0;
    while (!hs && waited < 100) begin
      @(negedge clk);
      check("busy_active", bus.busy, 1);
      hs = bus.local_wr_en;
      @(posedge clk); #1;
      if (!hs) waited++;
    end
    if (!hs) check("head_timeout", bus.local_wr_en, 1);
    if (!rnd_full) check("head_latency", waited, 0);

    pcyc = 0;
    for (int i = 0; i < len; i++) begin
      bus.pay_data = words[i];
      if (i == stall_at) begin
        bus.router_out_full = 1'b1;
        bus.pay_valid = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("stall_wr", bus.local_wr_en, 0);
          check("stall_pay_ready", bus.pay_ready, 0);
          @(posedge clk); #1;
        end
        bus.router_out_full = 1'b0;
      end
      if (i == gap_at) begin
        bus.pay_valid = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("gap_wr", bus.local_wr_en, 0);
          @(posedge clk); #1;
        end
      end
      hs = 1'b0;
      for (int g = 0; g < 100 && !hs; g++) begin
        bus.pay_valid = rand_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(negedge clk);
        hs = bus.pay_valid && bus.pay_ready;
        @(posedge clk); #1;
        pcyc++;
      end
      if (!hs) check("pay_timeout", hs, 1);
    end
    bus.pay_valid = 1'b0;
    exp_count++;
    if (!rnd_full && !rand_gaps && stall_at < 0 && gap_at < 0)
      check("payload_cycles", pcyc, len);
    check("pkt_count", bus.pkt_count, exp_count);
    check("busy_after", bus.busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.pkt_valid = 1'b0;
    bus.pkt_dest = '0;
    bus.pkt_len = '0;
    bus.pay_valid = 1'b0;
    bus.pay_data = '0;
    bus.router_out_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_pkt_ready", bus.pkt_ready, 1);
    check("rst_wr_en", bus.local_wr_en, 0);
    check("rst_flit", bus.local_in_flit, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_pkt_count", bus.pkt_count, 0);
    check("rst_err", bus.err_zero_len, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // Basic packet: flits 0x45, 0x91, 0xA2, 0xF3 back to back.
    words[0] = 6'h11; words[1] = 6'h22; words[2] = 6'h33;
    send_pkt(6'd5, 3, -1, -1, 1'b0);
    check("idle_flit", bus.local_in_flit, 0);

    // Router full for 3 cycles on the second body flit.
    send_pkt(6'd5, 3, 1, -1, 1'b0);

    // Payload source idle for 2 cycles mid-packet.
    words[3] = 6'h3F;
    send_pkt(6'd12, 4, -1, 2, 1'b0);

    // Zero-length request is dropped with a one-cycle error pulse.
    wait_accept(6'd3, '0);
    check("zl_err", bus.err_zero_len, 1);
    check("zl_ready", bus.pkt_ready, 1);
    check("zl_wr", bus.local_wr_en, 0);
    @(posedge clk); #1;
    check("zl_err_pulse", bus.err_zero_len, 0);
    check("zl_count", bus.pkt_count, exp_count);

    // Reset right after the head flit abandons the packet.
    exp_q.push_back({2'b01, 6'd9});
    wait_accept(6'd9, 4'd3);
    @(negedge clk);
    check("rr_head_wr", bus.local_wr_en, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_count = 0;
    check("rr_state", dbg_state, ST_IDLE);
    check("rr_wr_en", bus.local_wr_en, 0);
    check("rr_pkt_count", bus.pkt_count, 0);
    check("rr_flit", bus.local_in_flit, 0);
    check("rr_ready", bus.pkt_ready, 1);

    // Two back-to-back single-flit packets: HEAD TAIL idle HEAD TAIL.
    wr_cyc_q.delete();
    words[0] = 6'h2A;
    send_pkt(6'd2, 1, -1, -1, 1'b0);
    words[0] = 6'h15;
    send_pkt(6'd7, 1, -1, -1, 1'b0);
    check("b2b_writes", wr_cyc_q.size(), 4);
    if (wr_cyc_q.size() == 4) begin
      check("b2b_head_tail", wr_cyc_q[1] - wr_cyc_q[0], 1);
      check("b2b_idle_gap", wr_cyc_q[2] - wr_cyc_q[1], 2);
      check("b2b_head_tail2", wr_cyc_q[3] - wr_cyc_q[2], 1);
    end
    check("b2b_count", bus.pkt_count, 2);

    // Randomized traffic with router back-pressure and payload gaps.
    rnd_full = 1'b1;
    for (int p = 0; p < 30; p++) begin
      int len;
      len = $urandom_range(1, 15);
      for (int i = 0; i < len; i++) words[i] = FW'($urandom);
      send_pkt(FW'($urandom), len, -1, -1, 1'b1);
    end
    rnd_full = 1'b0;
    @(posedge clk); #1;
    bus.router_out_full = 1'b0;
    repeat (3) @(posedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
